// File: rtl/audio_frame_buffer.sv
// audio_frame_buffer: ping-pong frame buffer between a sample-rate audio
// stream and an AXI-Stream consumer (FFT stage).
//
// Two banks of FRAME_SIZE samples are filled alternately by the write side.
// Each complete bank is streamed out in write order, with tlast on the final
// sample. The write side is never stalled. A frame that starts while its
// target bank is still waiting to be read is dropped as a whole, and
// overrun_out pulses when that dropped frame would have completed.
//
// Ports:
//   clk_in          rising-edge clock for all logic
//   rst_in          synchronous, active-high reset
//   audio_valid_in  single-cycle strobe qualifying audio_in
//   audio_in        signed sample, SAMPLE_WIDTH bits
//   m_axis_tdata    sample left-aligned to OUT_WIDTH, low bits zero
//   m_axis_tvalid   tdata/tlast valid
//   m_axis_tready   downstream accepts
//   m_axis_tlast    high on the last sample of a frame
//   overrun_out     one-cycle pulse when a completed frame is discarded
//
// FRAME_SIZE must be a power of two and at least 4; OUT_WIDTH >= SAMPLE_WIDTH.

module audio_frame_buffer #(
  parameter int unsigned FRAME_SIZE   = 1024,
  parameter int unsigned SAMPLE_WIDTH = 8,
  parameter int unsigned OUT_WIDTH    = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    audio_valid_in,
  input  logic [SAMPLE_WIDTH-1:0] audio_in,
  output logic [OUT_WIDTH-1:0]    m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    overrun_out
);

  localparam int unsigned IDX_W   = $clog2(FRAME_SIZE);
  localparam int unsigned ADDR_W  = IDX_W + 1;
  localparam int unsigned PAD_W   = OUT_WIDTH - SAMPLE_WIDTH;
  localparam int unsigned DEPTH   = 2 * FRAME_SIZE;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRIME  = 2'd1,
    S_STREAM = 2'd2
  } state_e;

  // Sample storage: address = {bank, index}
  logic [SAMPLE_WIDTH-1:0] mem_q [DEPTH];

  // Write side
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic             wr_bank_q, wr_bank_d;
  logic             drop_q, drop_d;
  logic             overrun_q, overrun_d;
  logic [1:0]       full_q, full_d;
  logic             wr_last;
  logic             bank_busy;
  logic             drop_eff;
  logic             mem_we;

  // Read side
  state_e            state_q, state_d;
  logic              rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic [SAMPLE_WIDTH-1:0] rdata_q;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_done;
  logic              xfer;

  // Write-side bookkeeping: index, bank selection, full flags, frame drop
  always_comb begin
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    drop_d    = drop_q;
    overrun_d = 1'b0;
    full_d    = full_q;

    // A bank released by the final read this cycle is already free
    if (rd_done) begin
      full_d[rd_bank_q] = 1'b0;
    end

    bank_busy = full_q[wr_bank_q] && !(rd_done && (rd_bank_q == wr_bank_q));
    // The drop decision is taken on the first sample and held for the frame
    drop_eff  = (wr_idx_q == '0) ? bank_busy : drop_q;
    wr_last   = (wr_idx_q == IDX_W'(FRAME_SIZE - 1));
    mem_we    = audio_valid_in && !drop_eff;

    if (audio_valid_in) begin
      drop_d = drop_eff;
      if (wr_last) begin
        wr_idx_d = '0;
        drop_d   = 1'b0;
        if (drop_eff) begin
          // Discarded frame: bank pointer unchanged so frame order is kept
          overrun_d = 1'b1;
        end else begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
        end
      end else begin
        wr_idx_d = wr_idx_q + IDX_W'(1);
      end
    end
  end

  // Read FSM: state register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Read FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = S_PRIME;
        end
      end
      S_PRIME: begin
        state_d = S_STREAM;
      end
      S_STREAM: begin
        // full_d already includes a bank completed by the writer this cycle
        if (rd_done) begin
          state_d = full_d[~rd_bank_q] ? S_PRIME : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Read FSM: outputs. The read data register doubles as the output
  // holding register; a new read is issued only on a transfer, so tdata
  // stays stable under backpressure and streams without bubbles.
  always_comb begin
    rd_en     = 1'b0;
    rd_done   = 1'b0;
    rd_idx_d  = rd_idx_q;
    rd_bank_d = rd_bank_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    rd_addr   = {rd_bank_q, rd_idx_q};
    xfer      = tvalid_q && m_axis_tready;

    case (state_q)
      S_PRIME: begin
        rd_en    = 1'b1;
        rd_addr  = {rd_bank_q, IDX_W'(0)};
        rd_idx_d = IDX_W'(1);
        tvalid_d = 1'b1;
        tlast_d  = 1'b0;
      end
      S_STREAM: begin
        if (xfer) begin
          if (tlast_q) begin
            rd_done   = 1'b1;
            rd_idx_d  = '0;
            rd_bank_d = ~rd_bank_q;
            tvalid_d  = 1'b0;
            tlast_d   = 1'b0;
          end else begin
            rd_en    = 1'b1;
            rd_idx_d = rd_idx_q + IDX_W'(1);
            tlast_d  = (rd_idx_q == IDX_W'(FRAME_SIZE - 1));
          end
        end
      end
      default: begin
        rd_en = 1'b0;
      end
    endcase
  end

  // Control and read-data registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_idx_q  <= '0;
      wr_bank_q <= 1'b0;
      drop_q    <= 1'b0;
      overrun_q <= 1'b0;
      full_q    <= '0;
      rd_bank_q <= 1'b0;
      rd_idx_q  <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      wr_idx_q  <= wr_idx_d;
      wr_bank_q <= wr_bank_d;
      drop_q    <= drop_d;
      overrun_q <= overrun_d;
      full_q    <= full_d;
      rd_bank_q <= rd_bank_d;
      rd_idx_q  <= rd_idx_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      if (rd_en) begin
        rdata_q <= mem_q[rd_addr];
      end
    end
  end

  // Sample memory write port (contents survive reset)
  always_ff @(posedge clk_in) begin
    if (mem_we && !rst_in) begin
      mem_q[{wr_bank_q, wr_idx_q}] <= audio_in;
    end
  end

  // Left-align: sign bit lands in the MSB, low bits zero
  assign m_axis_tdata  = OUT_WIDTH'(rdata_q) << PAD_W;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign overrun_out   = overrun_q;

endmodule

// File: tb/tb_audio_frame_buffer.sv
// Directed bench for audio_frame_buffer (FRAME_SIZE=8, 8-bit in, 16-bit out).
module tb_audio_frame_buffer;

  localparam int unsigned FS = 8;
  localparam int unsigned SW = 8;
  localparam int unsigned OW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic [SW-1:0] ain;
  logic [OW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic          ovr;

  always #5 clk = ~clk;

  audio_frame_buffer #(
    .FRAME_SIZE  (FS),
    .SAMPLE_WIDTH(SW),
    .OUT_WIDTH   (OW)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .audio_valid_in(valid),
    .audio_in      (ain),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .overrun_out   (ovr)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc_cnt      = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Transfer / overrun / stability monitor, sampled on the falling edge
  logic [OW-1:0] got_data[$];
  logic          got_last[$];
  int            got_cyc[$];
  int            ov_count  = 0;
  int            ov_cyc    = -1;
  int            stall_err = 0;
  logic          prev_stall = 1'b0;
  logic [OW-1:0] prev_data;
  logic          prev_last;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (tvalid !== 1'b1 || tdata !== prev_data || tlast !== prev_last))
        stall_err++;
      if (tvalid === 1'b1 && tready === 1'b1) begin
        got_data.push_back(tdata);
        got_last.push_back(tlast);
        got_cyc.push_back(cyc_cnt);
      end
      if (ovr === 1'b1) begin
        ov_count++;
        ov_cyc = cyc_cnt;
      end
      prev_stall = (tvalid === 1'b1) && (tready !== 1'b1);
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic write_sample(input logic [SW-1:0] v);
    valid = 1'b1;
    ain   = v;
    tick();
    valid = 1'b0;
  endtask

  task automatic clear_mon();
    got_data.delete();
    got_last.delete();
    got_cyc.delete();
    ov_count  = 0;
    ov_cyc    = -1;
    stall_err = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; ain = '0; tready = 1'b0;
    repeat (3) tick();
    // More than a frame of strobes while in reset must be ignored
    for (int i = 0; i < 10; i++) begin
      valid = 1'b1;
      ain   = SW'(i + 1);
      tick();
    end
    valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (tvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_tvalid: got %b expected 0", tvalid); end
    tests_run++;
    if (tlast !== 1'b0) begin tests_failed++; $display("FAIL reset_tlast: got %b expected 0", tlast); end
    tests_run++;
    if (tdata !== 16'h0000) begin tests_failed++; $display("FAIL reset_tdata: got %h expected 0000", tdata); end
    tests_run++;
    if (ovr !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %b expected 0", ovr); end
    clear_mon();
    rst    = 1'b0;
    tready = 1'b1;
    idle(30);
    tests_run++;
    if (got_data.size() !== 0) begin tests_failed++; $display("FAIL reset_ignore_valid: got %0d beats expected 0", got_data.size()); end
    tests_run++;
    if (ov_count !== 0) begin tests_failed++; $display("FAIL reset_ignore_ovr: got %0d overruns expected 0", ov_count); end
  endtask

  task automatic test_basic();
    logic [OW-1:0] exp_d;
    bit found;
    clear_mon();
    tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      write_sample(SW'(i));
      if (i < 7) idle(3);
    end
    found = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (tvalid === 1'b1) found = 1'b1;
    end
    tests_run++;
    if (found !== 1'b1) begin tests_failed++; $display("FAIL basic_latency: tvalid seen=%b expected 1 within 3 cycles", found); end
    idle(12);
    tests_run++;
    if (got_data.size() !== 8) begin tests_failed++; $display("FAIL basic_count: got %0d beats expected 8", got_data.size()); end
    for (int i = 0; i < 8; i++) begin
      exp_d = OW'(i) << 8;
      tests_run++;
      if (i >= got_data.size()) begin
        tests_failed++; $display("FAIL basic_beat%0d: missing beat expected data=%h", i, exp_d);
      end else if (got_data[i] !== exp_d || got_last[i] !== (i == 7)) begin
        tests_failed++;
        $display("FAIL basic_beat%0d: got data=%h last=%b expected data=%h last=%b", i, got_data[i], got_last[i], exp_d, (i == 7));
      end
    end
    tests_run++;
    if (got_cyc.size() < 8 || (got_cyc[7] - got_cyc[0]) !== 7) begin
      tests_failed++; $display("FAIL basic_no_bubbles: beats not on 8 consecutive cycles (count %0d)", got_cyc.size());
    end
  endtask

  task automatic test_sign();
    logic [SW-1:0] smp [8];
    logic [OW-1:0] expv[8];
    smp  = '{8'h80, 8'hFF, 8'h7F, 8'h01, 8'hC0, 8'h40, 8'hFE, 8'h02};
    expv = '{16'h8000, 16'hFF00, 16'h7F00, 16'h0100, 16'hC000, 16'h4000, 16'hFE00, 16'h0200};
    clear_mon();
    tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      write_sample(smp[i]);
      idle(1);
    end
    idle(15);
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (i >= got_data.size()) begin
        tests_failed++; $display("FAIL sign_beat%0d: missing beat expected data=%h", i, expv[i]);
      end else if (got_data[i] !== expv[i] || got_last[i] !== (i == 7)) begin
        tests_failed++;
        $display("FAIL sign_beat%0d: got data=%h last=%b expected data=%h last=%b", i, got_data[i], got_last[i], expv[i], (i == 7));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0]   pat;
    logic [OW-1:0] exp_d;
    pat = 32'hB4E1_9A63;
    clear_mon();
    fork
      begin
        for (int k = 0; k < 32; k++) begin
          write_sample(SW'(8'h10 + k));
          idle(5);
        end
      end
      begin
        for (int c = 0; c < 300; c++) begin
          tready = pat[c % 32];
          tick();
        end
      end
    join
    tready = 1'b1;
    idle(20);
    tests_run++;
    if (got_data.size() !== 32) begin tests_failed++; $display("FAIL bp_count: got %0d beats expected 32", got_data.size()); end
    for (int k = 0; k < 32; k++) begin
      exp_d = {SW'(8'h10 + k), 8'h00};
      tests_run++;
      if (k >= got_data.size()) begin
        tests_failed++; $display("FAIL bp_beat%0d: missing beat expected data=%h", k, exp_d);
      end else if (got_data[k] !== exp_d || got_last[k] !== ((k % 8) == 7)) begin
        tests_failed++;
        $display("FAIL bp_beat%0d: got data=%h last=%b expected data=%h last=%b", k, got_data[k], got_last[k], exp_d, ((k % 8) == 7));
      end
    end
    tests_run++;
    if (stall_err !== 0) begin tests_failed++; $display("FAIL bp_stable: got %0d unstable stall cycles expected 0", stall_err); end
    tests_run++;
    if (ov_count !== 0) begin tests_failed++; $display("FAIL bp_overrun: got %0d overruns expected 0", ov_count); end
  endtask

  task automatic test_overrun();
    int k24;
    logic [OW-1:0] exp_d;
    clear_mon();
    tready = 1'b0;
    k24 = 0;
    for (int i = 0; i < 24; i++) begin
      write_sample(SW'(i));
      if (i == 23) k24 = cyc_cnt;
      idle(1);
    end
    idle(2);
    tests_run++;
    if (ov_count !== 1) begin tests_failed++; $display("FAIL ovr_count: got %0d pulses expected 1", ov_count); end
    tests_run++;
    if (ov_cyc !== k24) begin tests_failed++; $display("FAIL ovr_timing: got cycle %0d expected %0d", ov_cyc, k24); end
    tready = 1'b1;
    idle(40);
    tests_run++;
    if (got_data.size() !== 16) begin tests_failed++; $display("FAIL ovr_drain_count: got %0d beats expected 16", got_data.size()); end
    for (int i = 0; i < 16; i++) begin
      exp_d = OW'(i) << 8;
      tests_run++;
      if (i >= got_data.size()) begin
        tests_failed++; $display("FAIL ovr_beat%0d: missing beat expected data=%h", i, exp_d);
      end else if (got_data[i] !== exp_d || got_last[i] !== ((i % 8) == 7)) begin
        tests_failed++;
        $display("FAIL ovr_beat%0d: got data=%h last=%b expected data=%h last=%b", i, got_data[i], got_last[i], exp_d, ((i % 8) == 7));
      end
    end
    tests_run++;
    if (ov_count !== 1) begin tests_failed++; $display("FAIL ovr_count_after: got %0d pulses expected 1", ov_count); end
  endtask

  task automatic test_back_to_back();
    int kb;
    logic [OW-1:0] exp_d;
    clear_mon();
    tready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      write_sample(SW'(8'h20 + i));
      idle(1);
    end
    for (int i = 0; i < 7; i++) begin
      write_sample(SW'(8'h30 + i));
      idle(1);
    end
    idle(2);
    // Eight transfers of bank 0; the eighth lands on the edge capturing B7
    tready = 1'b1;
    repeat (7) tick();
    write_sample(8'h37);
    kb = cyc_cnt;
    idle(20);
    tests_run++;
    if (got_cyc.size() < 8 || got_cyc[7] !== kb - 1) begin
      tests_failed++; $display("FAIL b2b_coincide: tlast transfer not on completing write edge (beats %0d)", got_cyc.size());
    end
    tests_run++;
    if (ov_count !== 0) begin tests_failed++; $display("FAIL b2b_overrun: got %0d overruns expected 0", ov_count); end
    tests_run++;
    if (got_data.size() !== 16) begin tests_failed++; $display("FAIL b2b_count: got %0d beats expected 16", got_data.size()); end
    for (int i = 0; i < 16; i++) begin
      exp_d = (i < 8) ? {SW'(8'h20 + i), 8'h00} : {SW'(8'h30 + i - 8), 8'h00};
      tests_run++;
      if (i >= got_data.size()) begin
        tests_failed++; $display("FAIL b2b_beat%0d: missing beat expected data=%h", i, exp_d);
      end else if (got_data[i] !== exp_d || got_last[i] !== ((i % 8) == 7)) begin
        tests_failed++;
        $display("FAIL b2b_beat%0d: got data=%h last=%b expected data=%h last=%b", i, got_data[i], got_last[i], exp_d, ((i % 8) == 7));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [OW-1:0] exp_d;
    clear_mon();
    tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      write_sample(SW'(8'h50 + i));
      if (i < 7) idle(1);
    end
    // Partial next frame that reset must discard
    for (int i = 0; i < 3; i++) write_sample(8'h99);
    for (int c = 0; c < 20 && got_data.size() < 3; c++) tick();
    tests_run++;
    if (got_data.size() !== 3) begin tests_failed++; $display("FAIL rmid_pre: got %0d beats expected 3", got_data.size()); end
    rst    = 1'b1;
    tready = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (tvalid !== 1'b0) begin tests_failed++; $display("FAIL rmid_tvalid: got %b expected 0", tvalid); end
    tests_run++;
    if (tlast !== 1'b0) begin tests_failed++; $display("FAIL rmid_tlast: got %b expected 0", tlast); end
    tready = 1'b1;
    idle(20);
    tests_run++;
    if (got_data.size() !== 3) begin tests_failed++; $display("FAIL rmid_flushed: got %0d beats expected 3", got_data.size()); end
    clear_mon();
    for (int i = 0; i < 8; i++) begin
      write_sample(SW'(8'h60 + i));
      idle(1);
    end
    idle(15);
    tests_run++;
    if (got_data.size() !== 8) begin tests_failed++; $display("FAIL rmid_count: got %0d beats expected 8", got_data.size()); end
    for (int i = 0; i < 8; i++) begin
      exp_d = {SW'(8'h60 + i), 8'h00};
      tests_run++;
      if (i >= got_data.size()) begin
        tests_failed++; $display("FAIL rmid_beat%0d: missing beat expected data=%h", i, exp_d);
      end else if (got_data[i] !== exp_d || got_last[i] !== (i == 7)) begin
        tests_failed++;
        $display("FAIL rmid_beat%0d: got data=%h last=%b expected data=%h last=%b", i, got_data[i], got_last[i], exp_d, (i == 7));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 ns");
    $fatal(1, "timeout");
  end

endmodule
